// File: rtl/mc_controller.sv
// Multicycle RV32I-style control FSM: sequences fetch, decode, memory, ALU and
// branch steps, and faults any memory handshake that outlasts TIMEOUT cycles.
//
// state      | meaning
// -----------+------------------------------------------------------------
// s_fetch    | instruction read at PC; IR/OldPC and PC <= PC+4 on MemReady
// s_decode   | ALUOut <= OldPC + B-imm (branch target), dispatch on op
// s_memadr   | ALUOut <= rs1 + I/S-imm
// s_memread  | load request at ALUOut
// s_memwb    | rd <= MemData
// s_memwrite | store request at ALUOut
// s_execr    | ALUOut <= rs1 op rs2
// s_execi    | ALUOut <= rs1 op imm
// s_upper    | ALUOut <= U-imm (LUI) or OldPC + U-imm (AUIPC)
// s_aluwb    | rd <= ALUOut
// s_branch   | rs1 - rs2 compare, PC <= target when taken
// s_jal      | rd <= OldPC+4, PC <= target
// s_jalr     | PC <= rs1 + I-imm
// s_halt     | terminal until reset, Halt=1
// s_fault    | terminal until reset, Fault=1

module mc_controller #(
    parameter int TIMEOUT    = 16,
    parameter bit HAS_SYSTEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [3:0] Flag,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       Halt,
    output logic       Fault
);

    typedef enum logic [3:0] {
        s_fetch, s_decode, s_memadr, s_memread, s_memwb, s_memwrite,
        s_execr, s_execi, s_upper, s_aluwb, s_branch, s_jal, s_jalr,
        s_halt, s_fault
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic       mem_wait, wait_expired;

    logic       mem_req, mem_write_raw, ir_write_raw, pc_write_raw, reg_write_raw;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic       br_taken, br_bad;

    logic ovf, carry, neg, zero;
    assign {ovf, carry, neg, zero} = Flag;

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                              input logic is_reg);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= s_fetch;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    assign mem_wait     = ((state == s_fetch) || (state == s_memread) || (state == s_memwrite))
                          && !MemReady;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = neg ^ ovf;
            3'b101:  br_taken = !(neg ^ ovf);
            3'b110:  br_taken = !carry;
            3'b111:  br_taken = carry;
            default: br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_write_raw = 1'b0;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_ADD;
        imm_src       = IMM_I;
        result_src    = 2'b00;
        case (state)
            s_fetch: begin
                mem_req      = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = MemReady;
                pc_write_raw = MemReady;
                if (MemReady)          state_next = s_decode;
                else if (wait_expired) state_next = s_fault;
            end
            s_decode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_next = s_memadr;
                    OP_REG:            state_next = s_execr;
                    OP_IMM:            state_next = s_execi;
                    OP_LUI, OP_AUIPC:  state_next = s_upper;
                    OP_BRANCH:         state_next = s_branch;
                    OP_JAL:            state_next = s_jal;
                    OP_JALR:           state_next = s_jalr;
                    OP_SYSTEM:         state_next = HAS_SYSTEM ? s_halt : s_fault;
                    default:           state_next = s_fault;
                endcase
            end
            s_memadr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = op[5] ? IMM_S : IMM_I;
                state_next = op[5] ? s_memwrite : s_memread;
            end
            s_memread: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (MemReady)          state_next = s_memwb;
                else if (wait_expired) state_next = s_fault;
            end
            s_memwb: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                state_next    = s_fetch;
            end
            s_memwrite: begin
                mem_req       = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (MemReady)          state_next = s_fetch;
                else if (wait_expired) state_next = s_fault;
            end
            s_execr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_ctrl   = alu_decode(funct3, funct7b5, 1'b1);
                state_next = s_aluwb;
            end
            s_execi: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = IMM_I;
                alu_ctrl   = alu_decode(funct3, funct7b5, 1'b0);
                state_next = s_aluwb;
            end
            s_upper: begin
                // op[5] separates LUI (zero base) from AUIPC (OldPC base)
                alu_src_a  = op[5] ? 2'b11 : 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = IMM_U;
                state_next = s_aluwb;
            end
            s_aluwb: begin
                reg_write_raw = 1'b1;
                state_next    = s_fetch;
            end
            s_branch: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b00;
                alu_ctrl     = ALU_SUB;
                pc_write_raw = br_taken && !br_bad;
                state_next   = br_bad ? s_fault : s_fetch;
            end
            s_jal: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                pc_write_raw  = 1'b1;
                reg_write_raw = 1'b1;
                state_next    = s_fetch;
            end
            s_jalr: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                imm_src      = IMM_I;
                result_src   = 2'b10;
                pc_write_raw = 1'b1;
                state_next   = s_aluwb;
            end
            s_halt:  state_next = s_halt;
            s_fault: state_next = s_fault;
            default: state_next = s_fault;
        endcase
    end

    always_comb begin
        if (state_next != state) wait_next = '0;
        else if (mem_wait)       wait_next = wait_cnt + 8'd1;
        else                     wait_next = wait_cnt;
    end

    // Reset kills the request and all write strobes combinationally so an
    // in-flight access is abandoned without waiting for a clock edge.
    assign MemReq     = mem_req & ~reset;
    assign MemWrite   = mem_write_raw & ~reset;
    assign IRWrite    = ir_write_raw & ~reset;
    assign PCWrite    = pc_write_raw & ~reset;
    assign RegWrite   = reg_write_raw & ~reset;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ALUControl = alu_ctrl;
    assign ImmSrc     = imm_src;
    assign ResultSrc  = result_src;
    assign Halt       = (state == s_halt);
    assign Fault      = (state == s_fault);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected outputs go into a
// scoreboard queue and a negedge monitor pops and compares them.

module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] Flag;
    logic       MemReady;

    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Halt, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;

    logic       n_MemReq, n_MemWrite, n_AdrSrc, n_IRWrite, n_PCWrite, n_RegWrite, n_Halt, n_Fault;
    logic [1:0] n_ALUSrcA, n_ALUSrcB, n_ResultSrc;
    logic [3:0] n_ALUControl;
    logic [2:0] n_ImmSrc;

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT(16), .HAS_SYSTEM(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Flag(Flag), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
        .Halt(Halt), .Fault(Fault)
    );

    mc_controller #(.TIMEOUT(16), .HAS_SYSTEM(1'b0)) dut_nosys (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Flag(Flag), .MemReady(MemReady),
        .MemReq(n_MemReq), .MemWrite(n_MemWrite), .AdrSrc(n_AdrSrc), .IRWrite(n_IRWrite),
        .PCWrite(n_PCWrite), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
        .ALUControl(n_ALUControl), .ImmSrc(n_ImmSrc), .ResultSrc(n_ResultSrc),
        .Halt(n_Halt), .Fault(n_Fault)
    );

    typedef struct packed {
        logic       halt, fault, halt0, fault0, eq0;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] srcb, srca;
        logic       rw, pcw, irw, adr, mw, mr;
    } obs_t;

    obs_t obs;
    always_comb begin
        obs        = '0;
        obs.halt   = Halt;
        obs.fault  = Fault;
        obs.halt0  = n_Halt;
        obs.fault0 = n_Fault;
        obs.eq0    = ({n_MemReq, n_MemWrite, n_AdrSrc, n_IRWrite, n_PCWrite, n_RegWrite,
                       n_ALUSrcA, n_ALUSrcB, n_ALUControl, n_ImmSrc, n_ResultSrc} ==
                      {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc});
        obs.rs     = ResultSrc;
        obs.imm    = ImmSrc;
        obs.alu    = ALUControl;
        obs.srcb   = ALUSrcB;
        obs.srca   = ALUSrcA;
        obs.rw     = RegWrite;
        obs.pcw    = PCWrite;
        obs.irw    = IRWrite;
        obs.adr    = AdrSrc;
        obs.mw     = MemWrite;
        obs.mr     = MemReq;
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // {funct3, Flag(Ovf,Carry,Neg,Zero), taken}
    localparam logic [7:0] BRV [12] = '{
        8'b000_0001_1, 8'b000_0000_0, 8'b001_0001_0, 8'b001_0000_1,
        8'b100_0010_1, 8'b100_1010_0, 8'b101_1010_1, 8'b101_1000_0,
        8'b110_0000_1, 8'b110_0100_0, 8'b111_0100_1, 8'b111_0000_0
    };

    // {is_reg, funct3, funct7b5, ALUControl}
    localparam logic [8:0] ALV [12] = '{
        9'b1_000_1_0001, 9'b1_000_0_0000, 9'b0_000_1_0000, 9'b1_001_0_0010,
        9'b0_010_0_0011, 9'b1_011_0_0100, 9'b0_100_0_0101, 9'b1_101_0_0110,
        9'b1_101_1_0111, 9'b0_101_1_0111, 9'b0_110_0_1000, 9'b1_111_0_1001
    };

    function automatic obs_t x_base();
        obs_t e = '0;
        e.eq0 = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_fetch(input logic r);
        obs_t e = x_base();
        e.mr = 1'b1; e.srcb = 2'b10; e.rs = 2'b10; e.irw = r; e.pcw = r;
        return e;
    endfunction

    function automatic obs_t x_decode();
        obs_t e = x_base();
        e.srca = 2'b01; e.srcb = 2'b01; e.imm = 3'b010;
        return e;
    endfunction

    function automatic obs_t x_memadr(input logic st);
        obs_t e = x_base();
        e.srca = 2'b10; e.srcb = 2'b01; e.imm = st ? 3'b001 : 3'b000;
        return e;
    endfunction

    function automatic obs_t x_memread();
        obs_t e = x_base();
        e.mr = 1'b1; e.adr = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_memwb();
        obs_t e = x_base();
        e.rs = 2'b01; e.rw = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_memwrite();
        obs_t e = x_base();
        e.mr = 1'b1; e.mw = 1'b1; e.adr = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_exec(input logic is_r, input logic [3:0] a);
        obs_t e = x_base();
        e.srca = 2'b10; e.srcb = is_r ? 2'b00 : 2'b01; e.alu = a;
        return e;
    endfunction

    function automatic obs_t x_upper(input logic lui);
        obs_t e = x_base();
        e.imm = 3'b100; e.srcb = 2'b01; e.srca = lui ? 2'b11 : 2'b01;
        return e;
    endfunction

    function automatic obs_t x_aluwb();
        obs_t e = x_base();
        e.rw = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_branch(input logic t);
        obs_t e = x_base();
        e.srca = 2'b10; e.alu = 4'b0001; e.pcw = t;
        return e;
    endfunction

    function automatic obs_t x_jal();
        obs_t e = x_base();
        e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; e.rw = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_jalr();
        obs_t e = x_base();
        e.srca = 2'b10; e.srcb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_fault();
        obs_t e = x_base();
        e.fault = 1'b1; e.fault0 = 1'b1;
        return e;
    endfunction

    function automatic obs_t x_halt_sys();
        obs_t e = x_base();
        e.halt = 1'b1; e.fault0 = 1'b1;
        return e;
    endfunction

    function automatic obs_t rst_mask();
        obs_t m = '1;
        m.mr = 1'b0;
        return m;
    endfunction

    typedef struct {
        string nm;
        obs_t  e;
        obs_t  m;
    } sb_t;

    sb_t sbq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic cycm(input string nm, input obs_t e, input obs_t m);
        sb_t s;
        s.nm = nm; s.e = e; s.m = m;
        sbq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input obs_t e);
        cycm(nm, e, '1);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        MemReady = 1'b1;
        cycm("reset", x_fetch(1'b0), rst_mask());
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input string tag);
        MemReady = 1'b1;
        cyc({tag, "_fetch"}, x_fetch(1'b1));
        cyc({tag, "_decode"}, x_decode());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                sb_t s;
                s = sbq.pop_front();
                n_cmp++;
                if (((obs ^ s.e) & s.m) != '0) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h (mask %h) at %0t",
                             s.nm, obs, s.e, s.m, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Flag = '0; MemReady = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // lw, MemReady high in every memory cycle
        instr(OP_LOAD, 3'b010, 1'b0);
        fetch_decode("lw");
        cyc("lw_memadr", x_memadr(1'b0));
        cyc("lw_memread", x_memread());
        cyc("lw_memwb", x_memwb());

        // sw with waits in FETCH and a full-length wait in MEMWRITE
        instr(OP_STORE, 3'b010, 1'b0);
        MemReady = 1'b0;
        for (int i = 0; i < 10; i++) cyc("sw_fetch_wait", x_fetch(1'b0));
        fetch_decode("sw");
        MemReady = 1'b0;
        cyc("sw_memadr", x_memadr(1'b1));
        for (int i = 0; i < 15; i++) cyc("sw_memwrite_wait", x_memwrite());
        MemReady = 1'b1;
        cyc("sw_memwrite_done", x_memwrite());

        for (int i = 0; i < 12; i++) begin
            instr(OP_BRANCH, BRV[i][7:5], 1'b0);
            Flag = BRV[i][4:1];
            fetch_decode("br");
            cyc($sformatf("br_f3_%b_flag_%b", BRV[i][7:5], BRV[i][4:1]), x_branch(BRV[i][0]));
        end
        Flag = '0;

        for (int i = 0; i < 12; i++) begin
            instr(ALV[i][8] ? OP_REG : OP_IMM, ALV[i][7:5], ALV[i][4]);
            fetch_decode("alu");
            cyc($sformatf("exec_r%b_f3_%b_b30_%b", ALV[i][8], ALV[i][7:5], ALV[i][4]),
                x_exec(ALV[i][8], ALV[i][3:0]));
            cyc("alu_aluwb", x_aluwb());
        end

        instr(OP_LUI, 3'b000, 1'b0);
        fetch_decode("lui");
        cyc("lui_upper", x_upper(1'b1));
        cyc("lui_aluwb", x_aluwb());
        instr(OP_AUIPC, 3'b000, 1'b0);
        fetch_decode("auipc");
        cyc("auipc_upper", x_upper(1'b0));
        cyc("auipc_aluwb", x_aluwb());
        instr(OP_JAL, 3'b000, 1'b0);
        fetch_decode("jal");
        cyc("jal", x_jal());
        instr(OP_JALR, 3'b000, 1'b0);
        fetch_decode("jalr");
        cyc("jalr", x_jalr());
        cyc("jalr_aluwb", x_aluwb());

        // reserved branch funct3 faults without writing PC
        instr(OP_BRANCH, 3'b010, 1'b0);
        Flag = 4'b0001;
        fetch_decode("brbad");
        cyc("brbad_branch", x_branch(1'b0));
        cyc("brbad_fault", x_fault());
        cyc("brbad_fault_hold", x_fault());
        Flag = '0;
        do_reset();

        MemReady = 1'b0;
        for (int i = 0; i < 16; i++) cyc("to_fetch_wait", x_fetch(1'b0));
        MemReady = 1'b1;
        cyc("to_fault", x_fault());
        cyc("to_fault_hold", x_fault());
        do_reset();

        // MemReady on the last allowed cycle wins over the timeout
        instr(OP_LUI, 3'b000, 1'b0);
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++) cyc("edge_fetch_wait", x_fetch(1'b0));
        fetch_decode("edge");
        cyc("edge_upper", x_upper(1'b1));
        cyc("edge_aluwb", x_aluwb());

        instr(OP_STORE, 3'b000, 1'b0);
        fetch_decode("swto");
        MemReady = 1'b0;
        cyc("swto_memadr", x_memadr(1'b1));
        for (int i = 0; i < 16; i++) cyc("swto_memwrite_wait", x_memwrite());
        cyc("swto_fault", x_fault());
        do_reset();

        instr(OP_SYSTEM, 3'b000, 1'b0);
        fetch_decode("sys");
        cyc("sys_halt", x_halt_sys());
        cyc("sys_halt_hold", x_halt_sys());
        do_reset();

        instr(7'b0000000, 3'b000, 1'b0);
        fetch_decode("illegal");
        cyc("illegal_fault", x_fault());
        cyc("illegal_fault_hold", x_fault());
        do_reset();

        // reset asserted mid-cycle while a store is waiting
        instr(OP_STORE, 3'b010, 1'b0);
        fetch_decode("swrst");
        MemReady = 1'b0;
        cyc("swrst_memadr", x_memadr(1'b1));
        cyc("swrst_memwrite_wait", x_memwrite());
        reset = 1'b1;
        cycm("swrst_abort", x_fetch(1'b0), rst_mask());
        reset = 1'b0;
        fetch_decode("swrst_after");

        repeat (2) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
